// File: rtl/i2s_audio_path_if.sv
// Sample-side handshake of i2s_audio_path: source pair request/stage and received pair.
interface i2s_audio_path_if #(
   parameter int DW = 24
);
   logic          src_req;
   logic          src_valid;
   logic [DW-1:0] src_ldata;
   logic [DW-1:0] src_rdata;
   logic          rx_valid;
   logic [DW-1:0] rx_ldata;
   logic [DW-1:0] rx_rdata;

   modport master (
      input  src_req, rx_valid, rx_ldata, rx_rdata,
      output src_valid, src_ldata, src_rdata
   );

   modport slave (
      output src_req, rx_valid, rx_ldata, rx_rdata,
      input  src_valid, src_ldata, src_rdata
   );
endinterface

// File: rtl/i2s_audio_path.sv
// I2S master datapath: one frame counter drives sclk/lrclk, the per-frame TX word
// (mute/source/loopback/saturating mix, then attenuation) and the RX deserialiser.
module i2s_audio_path #(
   parameter int DW       = 24,
   parameter int SW       = 32,
   parameter int FS_RATIO = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      mode,
   input  logic [3:0]      atten,
   i2s_audio_path_if.slave aud,
   output logic            sclk,
   output logic            lrclk,
   output logic            sdo,
   input  logic            sdi,
   output logic            underrun
);
   localparam int DIV = FS_RATIO / (2 * SW);
   localparam int PW  = $clog2(DIV);
   localparam int BW  = $clog2(2 * SW);
   localparam int FW  = 2 * SW;

   localparam logic [PW-1:0] P_HALF = PW'(DIV / 2);
   localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
   localparam logic [BW-1:0] B_SW   = BW'(SW);
   localparam logic [BW-1:0] B_LAST = BW'(FW - 1);
   localparam logic [BW-1:0] B_LLSB = BW'(DW);
   localparam logic [BW-1:0] B_RMSB = BW'(SW + 1);
   localparam logic [BW-1:0] B_RLSB = BW'(SW + DW);

   // ph/slot run one cycle ahead of the pins; ph_q/slot_q give the frame
   // position the pins currently show, so all outputs are plain registers.
   logic [PW-1:0] ph, ph_q;
   logic [BW-1:0] slot, slot_q;

   logic          src_req_q;
   logic          rx_valid_q;
   logic [DW-1:0] rx_ldata_q, rx_rdata_q;
   logic [DW-1:0] rx_sh_l, rx_sh_r;
   logic [DW-1:0] stage_l, stage_r;
   logic          staged, armed;
   logic [FW-1:0] tx_sr, tx_word;

   logic          frame_load, rx_sample, rx_done, accept;
   logic [DW-1:0] rx_r_nxt, lb_l, lb_r, src_l, src_r;
   logic signed [DW-1:0] pick_l, pick_r, att_l, att_r;

   function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW:0]   s;
      logic [DW-1:0] r;
      s = {a[DW-1], a} + {b[DW-1], b};
      if (s[DW] != s[DW-1])
         r = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else
         r = s[DW-1:0];
      return r;
   endfunction

   assign frame_load = (slot_q == B_LAST) && (ph_q == P_LAST);
   assign rx_sample  = (ph_q == P_HALF);
   assign rx_done    = rx_sample && (slot_q == B_RLSB);
   assign rx_r_nxt   = {rx_sh_r[DW-2:0], sdi};
   assign accept     = aud.src_valid && (src_req_q || armed) && !frame_load;

   assign aud.src_req  = src_req_q;
   assign aud.rx_valid = rx_valid_q;
   assign aud.rx_ldata = rx_ldata_q;
   assign aud.rx_rdata = rx_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ph        <= '0;
         slot      <= '0;
         ph_q      <= '0;
         slot_q    <= '0;
         sclk      <= 1'b0;
         lrclk     <= 1'b0;
         src_req_q <= 1'b0;
      end else begin
         ph_q   <= ph;
         slot_q <= slot;
         if (ph == P_LAST) begin
            ph   <= '0;
            slot <= (slot == B_LAST) ? '0 : slot + 1'b1;
         end else begin
            ph <= ph + 1'b1;
         end
         sclk      <= (ph >= P_HALF);
         lrclk     <= (slot >= B_SW);
         src_req_q <= (slot == '0) && (ph == '0);
      end
   end

   // Loopback forwards the right word when it completes on the load edge itself.
   always_comb begin
      src_l   = staged ? stage_l : '0;
      src_r   = staged ? stage_r : '0;
      lb_l    = rx_done ? rx_sh_l  : rx_ldata_q;
      lb_r    = rx_done ? rx_r_nxt : rx_rdata_q;
      pick_l  = '0;
      pick_r  = '0;
      case (mode)
         2'd1: begin
            pick_l = src_l;
            pick_r = src_r;
         end
         2'd2: begin
            pick_l = lb_l;
            pick_r = lb_r;
         end
         2'd3: begin
            pick_l = sat_add(src_l, lb_l);
            pick_r = sat_add(src_r, lb_r);
         end
         default: begin
            pick_l = '0;
            pick_r = '0;
         end
      endcase
      att_l   = pick_l >>> atten;
      att_r   = pick_r >>> atten;
      tx_word = ({{(FW-DW){1'b0}}, att_l} << (FW - 1 - DW)) |
                ({{(FW-DW){1'b0}}, att_r} << (SW - 1 - DW));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_sr    <= '0;
         sdo      <= 1'b0;
         staged   <= 1'b0;
         armed    <= 1'b0;
         stage_l  <= '0;
         stage_r  <= '0;
         underrun <= 1'b0;
      end else begin
         if (ph_q == P_LAST) begin
            if (frame_load) begin
               sdo   <= tx_word[FW-1];
               tx_sr <= tx_word << 1;
            end else begin
               sdo   <= tx_sr[FW-1];
               tx_sr <= tx_sr << 1;
            end
         end
         if (frame_load) begin
            staged <= 1'b0;
            armed  <= 1'b0;
            if (mode[0] && !staged)
               underrun <= 1'b1;
         end else if (accept) begin
            stage_l <= aud.src_ldata;
            stage_r <= aud.src_rdata;
            staged  <= 1'b1;
            armed   <= 1'b0;
         end else if (src_req_q) begin
            armed <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sh_l    <= '0;
         rx_sh_r    <= '0;
         rx_ldata_q <= '0;
         rx_rdata_q <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (rx_sample) begin
            if (slot_q >= BW'(1) && slot_q <= B_LLSB)
               rx_sh_l <= {rx_sh_l[DW-2:0], sdi};
            if (slot_q >= B_RMSB && slot_q <= B_RLSB)
               rx_sh_r <= rx_r_nxt;
            if (rx_done) begin
               rx_ldata_q <= rx_sh_l;
               rx_rdata_q <= rx_r_nxt;
               rx_valid_q <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_i2s_audio_path.sv
// Frame-level bench for i2s_audio_path: drives I2S frames and source pairs, and checks
// pins and received pairs against a pair-level arithmetic model of each frame load.
module tb_i2s_audio_path;
   localparam int DW       = 24;
   localparam int SW       = 32;
   localparam int FS_RATIO = 256;
   localparam int DIV      = FS_RATIO / (2 * SW);
   localparam int RXV_CYC  = (SW + DW) * DIV + DIV / 2 + 1;
   localparam int MAXV     = (1 << (DW - 1)) - 1;
   localparam int MINV     = -(1 << (DW - 1));

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] mode = 2'd0;
   logic [3:0] atten = 4'd0;
   logic       sclk, lrclk, sdo, underrun;
   logic       sdi = 1'b0;

   i2s_audio_path_if #(.DW(DW)) aud ();

   i2s_audio_path #(.DW(DW), .SW(SW), .FS_RATIO(FS_RATIO)) dut (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode),
      .atten    (atten),
      .aud      (aud.slave),
      .sclk     (sclk),
      .lrclk    (lrclk),
      .sdo      (sdo),
      .sdi      (sdi),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Pair expected on sdo in the frame now running, and the sticky underrun flag.
   logic [DW-1:0] exp_tx_l = '0;
   logic [DW-1:0] exp_tx_r = '0;
   bit            exp_unr  = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [DW-1:0] model_ch(input int md, input int at, input bit stg,
                                              input logic [DW-1:0] s, input logic [DW-1:0] r);
      int sv, rv, v;
      logic [31:0] vb;
      sv = stg ? int'(signed'(s)) : 0;
      rv = int'(signed'(r));
      case (md)
         0:       v = 0;
         1:       v = sv;
         2:       v = rv;
         default: begin
            v = sv + rv;
            if (v > MAXV) v = MAXV;
            if (v < MINV) v = MINV;
         end
      endcase
      v  = v >>> at;
      vb = v;
      return vb[DW-1:0];
   endfunction

   task automatic release_reset();
      @(negedge clk);
      chk("rst_sclk", sclk, 0);
      chk("rst_lrclk", lrclk, 0);
      chk("rst_sdo", sdo, 0);
      chk("rst_src_req", aud.src_req, 0);
      chk("rst_rx_valid", aud.rx_valid, 0);
      chk("rst_rx_ldata", aud.rx_ldata, 0);
      chk("rst_rx_rdata", aud.rx_rdata, 0);
      chk("rst_underrun", underrun, 0);
      rst      = 1'b0;
      exp_tx_l = '0;
      exp_tx_r = '0;
      exp_unr  = 1'b0;
   endtask

   // One frame: md/at are the values present at frame load, v_at the cycle of the first
   // src_valid (-1 none), v2_at a later ignored valid, rl/rr the pair sent on sdi.
   task automatic run_frame(input int md, input int at, input int v_at, input int v2_at,
                            input logic [DW-1:0] sl, input logic [DW-1:0] sr,
                            input logic [DW-1:0] rl, input logic [DW-1:0] rr,
                            input int rst_at);
      logic [2*SW-1:0] cap, exp_frame;
      logic [DW-1:0]   got_rl, got_rr;
      int              clk_err, stab_err, n_rxv, rxv_cyc, b, p;
      bit              stg;
      cap = '0; got_rl = '0; got_rr = '0;
      clk_err = 0; stab_err = 0; n_rxv = 0; rxv_cyc = -1;
      for (int c = 0; c < FS_RATIO; c++) begin
         @(negedge clk);
         b = c / DIV;
         p = c % DIV;
         if (c == 0) begin
            chk("src_req_c0", aud.src_req, 1);
            chk("underrun", underrun, exp_unr);
         end
         if (c == rst_at) begin
            rst           = 1'b1;
            aud.src_valid = 1'b0;
            return;
         end
         if (sclk !== (p >= DIV / 2) || lrclk !== (b >= SW) || aud.src_req !== (c == 0))
            clk_err++;
         if (p == 0) cap[2*SW-1-b] = sdo;
         else if (sdo !== cap[2*SW-1-b]) stab_err++;
         if (aud.rx_valid) begin
            n_rxv++;
            if (rxv_cyc < 0) rxv_cyc = c;
            got_rl = aud.rx_ldata;
            got_rr = aud.rx_rdata;
         end
         if (b >= 1 && b <= DW) sdi = rl[DW-b];
         else if (b >= SW + 1 && b <= SW + DW) sdi = rr[SW+DW-b];
         else sdi = 1'($urandom);
         mode  = (c >= FS_RATIO - 8) ? 2'(md) : 2'($urandom);
         atten = (c >= FS_RATIO - 8) ? 4'(at) : 4'($urandom);
         if (c == v_at) begin
            aud.src_valid = 1'b1;
            aud.src_ldata = sl;
            aud.src_rdata = sr;
         end else begin
            aud.src_valid = (c == v2_at);
            aud.src_ldata = DW'($urandom);
            aud.src_rdata = DW'($urandom);
         end
      end
      exp_frame = '0;
      for (int k = 1; k <= DW; k++) begin
         exp_frame[2*SW-1-k]      = exp_tx_l[DW-k];
         exp_frame[2*SW-1-SW-k]   = exp_tx_r[DW-k];
      end
      chk("tx_frame", cap, exp_frame);
      chk("clk_gen_errs", clk_err, 0);
      chk("sdo_stable_errs", stab_err, 0);
      chk("rx_pulses", n_rxv, 1);
      chk("rx_cycle", rxv_cyc, RXV_CYC);
      chk("rx_l", got_rl, rl);
      chk("rx_r", got_rr, rr);
      stg = (v_at >= 0 && v_at <= FS_RATIO - 2);
      if ((md == 1 || md == 3) && !stg) exp_unr = 1'b1;
      exp_tx_l = model_ch(md, at, stg, sl, rl);
      exp_tx_r = model_ch(md, at, stg, sr, rr);
   endtask

   initial begin
      int md, at, va, v2;
      aud.src_valid = 1'b0;
      aud.src_ldata = '0;
      aud.src_rdata = '0;
      @(negedge clk);
      release_reset();

      run_frame(1, 0, 0, -1, 24'h7FFFFF, 24'h800001, 24'h0F0F0F, 24'h3C3C3C, -1);
      run_frame(1, 0, 3, 40, 24'h7FFFFF, 24'h800001, 24'h55AA55, 24'hAA55AA, -1);
      run_frame(2, 0, -1, -1, 24'h0, 24'h0, 24'h123456, 24'hFEDCBA, -1);
      run_frame(3, 0, 10, -1, 24'h700000, 24'h900000, 24'h200000, 24'hA00000, -1);
      run_frame(1, 3, 7, -1, 24'hFFFF00, 24'h000100, 24'h000001, 24'hFFFFFF, -1);
      run_frame(1, 0, -1, -1, 24'h0, 24'h0, 24'h765432, 24'h89ABCD, -1);
      run_frame(0, 0, -1, -1, 24'h0, 24'h0, 24'h111111, 24'h222222, -1);
      run_frame(1, 0, FS_RATIO - 1, -1, 24'h333333, 24'h444444, 24'h555555, 24'h666666, -1);
      run_frame(3, 2, FS_RATIO - 1, -1, 24'h777777, 24'h888888, 24'h400000, 24'hC00000, -1);

      for (int k = 0; k < 12; k++) begin
         md = $urandom_range(0, 3);
         at = $urandom_range(0, 15);
         va = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, FS_RATIO - 1));
         v2 = -1;
         if (va >= 0 && va < FS_RATIO - 1 && $urandom_range(0, 1) == 1)
            v2 = $urandom_range(va + 1, FS_RATIO - 1);
         run_frame(md, at, va, v2, DW'($urandom), DW'($urandom), DW'($urandom),
                   DW'($urandom), -1);
      end

      run_frame(1, 0, 5, -1, 24'h0ABCDE, 24'h0FEDCB, 24'h135790, 24'h246801, 100);
      release_reset();
      run_frame(1, 0, 0, -1, 24'h3FFFFF, 24'hC00000, 24'h0000FF, 24'hFFFF00, -1);
      run_frame(3, 1, 50, 60, 24'h100000, 24'hF00000, 24'h050000, 24'hFB0000, -1);
      run_frame(0, 0, -1, -1, 24'h0, 24'h0, 24'h2468AC, 24'h13579B, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/i2s_audio_path.md
# i2s_audio_path

Parametrised stereo audio datapath between the sample sources and the codec pins. It combines I2S clock generation, transmit serialisation and receive deserialisation in one clock domain. A frame-level source mux selects mute, source, ADC loopback or saturating mix, followed by a per-frame attenuation shift. It replaces the fixed-width clock-generator/serialiser pairing at the top level and adds configurable slot width, mode control, attenuation and underrun detection.

## Interface
- DW, 24: sample width, two's complement; DW ≤ SW-1
- SW, 32: slot width in sclk periods per channel
- FS_RATIO, 256: clk cycles per stereo frame; DIV = FS_RATIO/(2*SW) must be an even integer ≥ 2
- clk  in  1  master clock, also driven to codec mclk externally
- rst  in  1  synchronous, active-high reset
- mode  in  2  0 mute, 1 source, 2 loopback, 3 mix
- atten  in  4  arithmetic right-shift applied to TX samples (0..15)
- src_req  out  1  one-cycle pulse requesting next source sample pair
- src_valid  in  1  source pair valid this cycle
- src_ldata, src_rdata  in  DW  source samples
- sclk  out  1  bit clock
- lrclk  out  1  word select, 0 = left
- sdo  out  1  DAC serial data
- sdi  in  1  ADC serial data
- rx_valid  out  1  one-cycle pulse, new RX pair
- rx_ldata, rx_rdata  out  DW  received samples
- underrun  out  1  sticky: a frame was loaded with no source pair staged

## Operation
- Frame counter cnt runs 0..FS_RATIO-1 and wraps. Bit slot b = cnt/DIV (0..2*SW-1); phase p = cnt mod DIV.
- sclk = 1 when p ≥ DIV/2, else 0. lrclk = 0 for b < SW, 1 for b ≥ SW.
- I2S framing with one-bit delay. The left MSB occupies slot 1 and the LSB slot DW. The right MSB occupies slot SW+1 and the LSB slot SW+DW. All other slots carry 0.
- TX: sdo updates at p = 0 (sclk falling) from a 2*SW-bit shift register.
- Staging: src_req pulses at cnt = 0. The first src_valid after each req latches src_ldata/src_rdata into staging and sets staged. Further valids before the next req are ignored.
- At cnt = FS_RATIO-1 (frame load), the TX word is computed and loaded:
  - Mode, atten and staged data are sampled here.
  - mode 0: 0.
  - mode 1: staged pair, or 0 if not staged.
  - mode 2: last rx pair.
  - mode 3: staged + last rx, each channel computed at DW+1 bits and saturated to [-2^(DW-1), 2^(DW-1)-1]. An unstaged source counts as 0.
  - Then >>> atten (arithmetic), then placed MSB-first into the slot layout.
- underrun sets when mode ∈ {1,3} and staged = 0 at frame load; it clears only on rst.
- staged clears at frame load.
- RX: sdi is sampled at p = DIV/2 (sclk rising) in slots 1..DW (left) and SW+1..SW+DW (right), MSB first.
- After the right LSB sample, rx_ldata/rx_rdata update and rx_valid pulses once. Both words update in the same cycle.
- Reset mid-frame: all state returns to reset values on the next edge, and the frame restarts at cnt = 0.

## Timing
- Reset values: cnt 0, sclk 0, lrclk 0, sdo 0, src_req 0, rx_valid 0, rx_ldata/rx_rdata 0, underrun 0, staged 0, TX shift register 0.
- First src_req: cnt = 0 of the first frame after rst deassert, i.e. the cycle after rst low.
- First frame after reset transmits zeros. A pair staged during frame N is serialised in frame N+1.
- rx_valid is asserted the cycle after cnt = (SW+DW)*DIV + DIV/2, for exactly one clk per frame.
- Loopback latency: a sample received in frame N is transmitted in frame N+1.
- src_valid in the same cycle as src_req is accepted.
- src_valid at cnt = FS_RATIO-1 is too late for that load: it is not staged for this frame and the underrun rule applies.

## Test plan
All scenarios use DW=24, SW=32, FS_RATIO=256 (DIV=4) unless stated otherwise.
- Clocking: release reset → sclk period 4 clk, lrclk period 256 clk, lrclk falls at cnt 0, src_req every 256 cycles starting the first cycle after reset.
- Source TX: mode 1, atten 0, answer each req with L=0x7FFFFF, R=0x800001 → frame N+1 sdo shows the left MSB in slot 1 and the right MSB in slot 33, zeros in slots 25..32, and the bits decode back exactly; underrun stays 0.
- Loopback RX/TX: mode 2, drive sdi with an I2S frame L=0x123456, R=0xFEDCBA → rx_valid pulses once with those values; the next frame's sdo carries the same pair.
- Mix saturation: mode 3, source L=0x700000, ADC L=0x200000; source R=0x900000, ADC R=0xA00000 → TX L=0x7FFFFF, R=0x800000.
- Attenuation/underrun: mode 1, atten 3, source L=0xFFFF00 (−256) → TX L=0xFFFFE0 (−32). Then withhold src_valid for one frame → that frame transmits 0 and underrun sets and stays 1 until rst.
- Reset mid-frame: assert rst at cnt=100 for 1 cycle → all outputs read their reset values the following cycle, and src_req pulses the cycle after rst deasserts.
